hwpe_stream_tcdm_load_ctrl: RTL and testbench

- Load-request engine that sits directly upstream of the TCDM load FIFO stage.
- Generates a strided word-address sequence and issues read requests on a TCDM master port, which feeds the FIFO's slave side.
- Consumes the FIFO's buffered responses, forwards them as a 32-bit HWPE stream to the datapath, and bounds in-flight reads with an outstanding-request counter.
- Driven by a start/done job interface from the engine controller.

---
 rtl/hwpe_stream_tcdm_load_ctrl.sv | 135 +++++++++++++
 tb/tb_hwpe_stream_tcdm_load_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_load_ctrl.sv
// hwpe_stream_tcdm_load_ctrl: strided TCDM load-request engine feeding a 32-bit HWPE stream
// Optional grant-stall counter enabled by defining HWPE_STREAM_TCDM_LOAD_CTRL_PERF_EN.
module hwpe_stream_tcdm_load_ctrl #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [31:0]          stride_i,
    input  logic [CNT_WIDTH-1:0] nb_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [31:0]          tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [3:0]           tcdm_be_o,
    output logic [31:0]          tcdm_data_o,
    input  logic [31:0]          tcdm_r_data_i,
    input  logic                 tcdm_r_valid_i,
    output logic                 tcdm_r_ready_o,
    output logic [31:0]          stream_data_o,
    output logic [3:0]           stream_strb_o,
    output logic                 stream_valid_o,
    input  logic                 stream_ready_i,
    output logic [31:0]          perf_stall_o
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]           r_state;
    logic [31:0]          r_addr;
    logic [31:0]          r_stride;
    logic [CNT_WIDTH-1:0] r_nb;
    logic [CNT_WIDTH-1:0] r_req_cnt;
    logic [CNT_WIDTH-1:0] r_rsp_cnt;
    logic [OW-1:0]        r_out;
    logic [1:0]           w_state_nxt;
    logic                 w_clr;
    logic                 w_start;
    logic                 w_rsp_act;
    logic                 w_req;
    logic                 w_gnt;
    logic                 w_rsp_hs;
    logic                 w_rsp_dec;
    logic                 w_last_req;
    logic                 w_last_rsp;
    assign w_clr      = rst_i | clear_i;
    assign w_start    = (r_state == IDLE) & start_i;
    assign w_rsp_act  = (r_state == ISSUE) | (r_state == DRAIN);
    assign w_req      = (r_state == ISSUE) & (r_out < MAX_O);
    assign w_gnt      = w_req & tcdm_gnt_i;
    assign w_rsp_hs   = w_rsp_act & tcdm_r_valid_i & stream_ready_i;
    assign w_rsp_dec  = w_rsp_hs & (r_out != '0);
    assign w_last_req = (r_req_cnt + ONE) == r_nb;
    assign w_last_rsp = (r_rsp_cnt + ONE) == r_nb;
    assign busy_o         = r_state != IDLE;
    assign done_o         = r_state == DONE;
    assign tcdm_req_o     = w_req;
    assign tcdm_add_o     = r_addr;
    assign tcdm_wen_o     = 1'b1;
    assign tcdm_be_o      = 4'hF;
    assign tcdm_data_o    = '0;
    assign tcdm_r_ready_o = w_rsp_act ? stream_ready_i : 1'b1;
    assign stream_valid_o = w_rsp_act & tcdm_r_valid_i;
    assign stream_data_o  = tcdm_r_data_i;
    assign stream_strb_o  = 4'hF;
    // job sequencing: issue until the last grant, drain until the last response, pulse done
    always_comb begin
        w_state_nxt = (r_state == IDLE)  ? (start_i ? ((nb_words_i != '0) ? ISSUE : DONE) : IDLE) :
                      (r_state == ISSUE) ? ((w_gnt && w_last_req) ? DRAIN : ISSUE) :
                      (r_state == DRAIN) ? ((w_rsp_hs && w_last_rsp) ? DONE : DRAIN) : IDLE;
    end
    // state, address generator and request/response/outstanding bookkeeping
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_stride  <= '0;
            r_nb      <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_out     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_addr    <= base_addr_i;
                r_stride  <= stride_i;
                r_nb      <= nb_words_i;
                r_req_cnt <= '0;
                r_rsp_cnt <= '0;
                r_out     <= '0;
            end else begin
                if (w_gnt) begin
                    r_addr    <= r_addr + r_stride;
                    r_req_cnt <= r_req_cnt + ONE;
                end
                if (w_rsp_hs)
                    r_rsp_cnt <= r_rsp_cnt + ONE;
                r_out <= r_out + OW'(w_gnt) - OW'(w_rsp_dec);
            end
        end
    end
`ifdef HWPE_STREAM_TCDM_LOAD_CTRL_PERF_EN
    logic [31:0] r_stall;
    logic        w_stall_inc;
    assign w_stall_inc  = (w_req & ~tcdm_gnt_i) | ((r_state == ISSUE) & (r_out == MAX_O));
    assign perf_stall_o = r_stall;
    // saturating count of cycles the issue side waits on grant or on the outstanding limit
    always_ff @(posedge clk_i) begin
        if (w_clr || w_start)
            r_stall <= '0;
        else if (w_stall_inc && (r_stall != 32'hFFFF_FFFF))
            r_stall <= r_stall + 32'd1;
    end
`else
    assign perf_stall_o = '0;
`endif
`ifndef SYNTHESIS
    // a response with nothing in flight means the load FIFO handed back an unrequested word
    always_ff @(posedge clk_i) begin
        if (!w_clr) begin
            assert (!(w_rsp_hs && (r_out == '0)));
            assert (r_out <= MAX_O);
        end
    end
`endif
endmodule

// File: tb/tb_hwpe_stream_tcdm_load_ctrl.sv
// tb_hwpe_stream_tcdm_load_ctrl: scoreboard bench with a TCDM/FIFO slave model and job-level reference
module tb_hwpe_stream_tcdm_load_ctrl;
    localparam int MAX = 2;
    localparam int CW  = 16;
    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [31:0]   base_addr_i = '0;
    logic [31:0]   stride_i = '0;
    logic [CW-1:0] nb_words_i = '0;
    logic          busy_o, done_o, tcdm_req_o, tcdm_wen_o, tcdm_r_ready_o, stream_valid_o;
    logic          tcdm_gnt_i = 1'b0;
    logic          tcdm_r_valid_i = 1'b0;
    logic          stream_ready_i = 1'b1;
    logic [31:0]   tcdm_add_o, tcdm_data_o, stream_data_o, perf_stall_o;
    logic [31:0]   tcdm_r_data_i = '0;
    logic [3:0]    tcdm_be_o, stream_strb_o;

    hwpe_stream_tcdm_load_ctrl #(.MAX_OUTSTANDING(MAX), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i), .nb_words_i(nb_words_i),
        .busy_o(busy_o), .done_o(done_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_ready_o(tcdm_r_ready_o),
        .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o),
        .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
        .perf_stall_o(perf_stall_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[1:0], a[31:2]};
    endfunction

    // reference model state (job level)
    bit          mon_en = 0;
    bit          m_active = 0;
    bit          m_done = 0;
    int          m_issue = 0;
    int          m_rsp = 0;
    int          m_infl = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] eaddr[$];
    logic [31:0] edata[$];
    int          gcnt = 0;
    int          dcnt = 0;
    int          rhs_cnt = 0;
    bit          f_gnt = 0;
    bit          f_rhs = 0;
    bit          f_flush = 1;
    logic [31:0] f_addr = '0;

    // environment modes driven by the main sequence
    int  gnt_mode = 1;
    bit  rsp_rand = 0;
    bit  hold = 0;
    bit  stray = 0;
    bit  ready_rand = 0;
    bit  ready_fix = 1;
    int  rsp_limit = 0;
    int  d0 = 0;
    logic [31:0] rq[$];

    // monitor / scoreboard: evaluates the handshakes that will happen at the next rising edge
    always @(negedge clk) begin
        bit er, beat, nd, si;
        logic [31:0] a;
        logic [31:0] exp_perf;
        er   = m_active && m_issue > 0 && m_infl < MAX;
        beat = m_active && stream_valid_o && stream_ready_i;
        si   = (er && !tcdm_gnt_i) || (m_active && m_issue > 0 && m_infl == MAX);
`ifdef HWPE_STREAM_TCDM_LOAD_CTRL_PERF_EN
        exp_perf = m_stall;
`else
        exp_perf = 32'd0;
`endif
        if (mon_en) begin
            chk("req", {31'd0, tcdm_req_o}, {31'd0, er});
            chk("busy", {31'd0, busy_o}, {31'd0, m_active || m_done});
            chk("done", {31'd0, done_o}, {31'd0, m_done});
            chk("consts", {tcdm_wen_o, tcdm_be_o, stream_strb_o}, {1'b1, 4'hF, 4'hF});
            chk("wdata", tcdm_data_o, 32'd0);
            chk("perf", perf_stall_o, exp_perf);
            if (m_active) begin
                chk("svalid", {31'd0, stream_valid_o}, {31'd0, tcdm_r_valid_i});
                chk("rready", {31'd0, tcdm_r_ready_o}, {31'd0, stream_ready_i});
            end else begin
                chk("svalid_idle", {31'd0, stream_valid_o}, 32'd0);
                chk("rready_idle", {31'd0, tcdm_r_ready_o}, 32'd1);
            end
            if (tcdm_req_o && tcdm_gnt_i) begin
                if (eaddr.size() == 0) chk("grant_extra", tcdm_add_o, 32'hDEAD_BEEF);
                else chk("addr", tcdm_add_o, eaddr.pop_front());
            end
            if (beat) begin
                if (edata.size() == 0) chk("beat_extra", stream_data_o, 32'hDEAD_BEEF);
                else chk("data", stream_data_o, edata.pop_front());
            end
        end
        f_gnt   = tcdm_req_o && tcdm_gnt_i && !rst_i && !clear_i;
        f_addr  = tcdm_add_o;
        f_rhs   = tcdm_r_valid_i && tcdm_r_ready_o && !rst_i && !clear_i;
        f_flush = rst_i || clear_i;
        if (f_gnt) gcnt++;
        if (f_rhs) rhs_cnt++;
        if (done_o === 1'b1) dcnt++;
        nd = 0;
        if (er && tcdm_gnt_i) begin
            m_issue--;
            m_infl++;
        end
        if (beat) begin
            m_infl--;
            m_rsp--;
            if (m_rsp == 0) begin
                m_active = 0;
                nd = 1;
            end
        end
        if (!m_active && !m_done && start_i) begin
            if (nb_words_i == 0) nd = 1;
            else begin
                m_active = 1;
                m_issue  = int'(nb_words_i);
                m_rsp    = int'(nb_words_i);
                m_infl   = 0;
                for (int i = 0; i < int'(nb_words_i); i++) begin
                    a = base_addr_i + stride_i * 32'(i);
                    eaddr.push_back(a);
                    edata.push_back(mem(a));
                end
            end
            m_stall = 0;
        end else if (si && m_stall != 32'hFFFF_FFFF) m_stall++;
        m_done = nd;
        if (rst_i || clear_i) begin
            m_active = 0;
            m_done   = 0;
            m_issue  = 0;
            m_rsp    = 0;
            m_infl   = 0;
            m_stall  = 0;
            eaddr.delete();
            edata.delete();
        end
    end

    // TCDM grant source and load-FIFO response model
    always @(posedge clk) begin
        #2;
        if (f_flush) rq.delete();
        else begin
            if (f_rhs && rq.size() > 0) void'(rq.pop_front());
            if (f_gnt) rq.push_back(mem(f_addr));
        end
        tcdm_gnt_i     = (gnt_mode == 0) ? ($urandom % 3 != 0) : (gnt_mode == 1);
        stream_ready_i = ready_rand ? ($urandom % 4 != 0) : ready_fix;
        if (stray) begin
            tcdm_r_valid_i = 1'b1;
            tcdm_r_data_i  = $urandom;
        end else if (rq.size() > 0 && (!hold || rhs_cnt < rsp_limit) && (!rsp_rand || $urandom % 3 != 0)) begin
            tcdm_r_valid_i = 1'b1;
            tcdm_r_data_i  = rq[0];
        end else begin
            tcdm_r_valid_i = 1'b0;
            tcdm_r_data_i  = $urandom;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] s, input int n);
        d0          = dcnt;
        start_i     = 1'b1;
        base_addr_i = b;
        stride_i    = s;
        nb_words_i  = CW'(n);
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic finish_job(input string nm, input int exp_cyc);
        int c = 0;
        while (busy_o && c < 3000) begin
            cyc(1);
            c++;
        end
        chk({nm, "_timeout"}, {31'd0, busy_o}, 32'd0);
        if (exp_cyc >= 0) chk({nm, "_cycles"}, c, exp_cyc);
        chk({nm, "_done_cnt"}, dcnt, d0 + 1);
        chk({nm, "_addr_left"}, eaddr.size(), 0);
        chk({nm, "_data_left"}, edata.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        int g0;
        int w;
        logic [31:0] s;
        int n;
        cyc(3);
        rst_i  = 1'b0;
        mon_en = 1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_req", {31'd0, tcdm_req_o}, 32'd0);
        chk("rst_svalid", {31'd0, stream_valid_o}, 32'd0);
        chk("rst_rready", {31'd0, tcdm_r_ready_o}, 32'd1);
        chk("rst_add", tcdm_add_o, 32'd0);
        chk("rst_perf", perf_stall_o, 32'd0);

        start_job(32'h1000, 32'd4, 4);
        finish_job("basic", 6);

        hold      = 1;
        rsp_limit = rhs_cnt;
        g0        = gcnt;
        start_job(32'h4000, 32'd8, 6);
        cyc(10);
        chk("limit_grants", gcnt - g0, MAX);
        chk("limit_req", {31'd0, tcdm_req_o}, 32'd0);
        rsp_limit = rhs_cnt + 1;
        cyc(6);
        chk("limit_one_more", gcnt - g0, MAX + 1);
        chk("limit_req2", {31'd0, tcdm_req_o}, 32'd0);
        hold = 0;
        finish_job("limit", -1);

        start_job(32'h280, 32'd4, 6);
        cyc(2);
        ready_fix = 0;
        repeat (10) begin
            cyc(1);
            chk("bp_rready", {31'd0, tcdm_r_ready_o}, 32'd0);
        end
        ready_fix = 1;
        finish_job("backpressure", -1);

        g0 = gcnt;
        d0 = dcnt;
        start_i    = 1'b1;
        nb_words_i = '0;
        cyc(1);
        start_i = 1'b0;
        chk("nb0_done", {31'd0, done_o}, 32'd1);
        cyc(1);
        chk("nb0_done_low", {31'd0, done_o}, 32'd0);
        chk("nb0_busy", {31'd0, busy_o}, 32'd0);
        chk("nb0_no_req", gcnt, g0);
        chk("nb0_done_cnt", dcnt, d0 + 1);
        start_job(32'h8, 32'hFFFF_FFFC, 4);
        finish_job("neg_stride", 6);

        hold      = 1;
        rsp_limit = rhs_cnt;
        g0        = gcnt;
        start_job(32'h6000, 32'd4, 6);
        w = 0;
        while (gcnt - g0 < MAX && w < 50) begin
            cyc(1);
            w++;
        end
        chk("clr_outstanding", gcnt - g0, MAX);
        cyc(2);
        d0      = dcnt;
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("clr_busy", {31'd0, busy_o}, 32'd0);
        chk("clr_done", {31'd0, done_o}, 32'd0);
        stray = 1;
        hold  = 0;
        repeat (4) begin
            cyc(1);
            chk("stray_svalid", {31'd0, stream_valid_o}, 32'd0);
            chk("stray_rready", {31'd0, tcdm_r_ready_o}, 32'd1);
        end
        stray = 0;
        cyc(1);
        chk("clr_no_done", dcnt, d0);
        start_job(32'h7000, 32'd12, 2);
        finish_job("after_clear", -1);

        gnt_mode   = 0;
        ready_rand = 1;
        rsp_rand   = 1;
        for (int j = 0; j < 25; j++) begin
            n = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 12);
            case ($urandom % 3)
                0:       s = 32'd4;
                1:       s = 32'hFFFF_FFFC;
                default: s = $urandom;
            endcase
            start_job($urandom, s, n);
            finish_job("random", -1);
            cyc($urandom_range(0, 3));
        end

        gnt_mode   = 2;
        ready_rand = 0;
        ready_fix  = 1;
        rsp_rand   = 0;
        cyc(1);
        start_job(32'h9000, 32'd4, 1);
        cyc(4);
        gnt_mode = 1;
        finish_job("perf", -1);
`ifdef HWPE_STREAM_TCDM_LOAD_CTRL_PERF_EN
        chk("perf_stall", perf_stall_o, 32'd5);
`else
        chk("perf_stall", perf_stall_o, 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
